rand_delay_arb: RTL and testbench

//  Round-robin arbiter for one shared resource (e.g. the single SRAM port behind IFU/LSU).

---
 rtl/rand_delay_arb_if.sv | 29 ++
 rtl/rand_delay_arb.sv | 137 +++++++++++++
 tb/tb_rand_delay_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rand_delay_arb_if.sv
// Handshake bundle between requesters and the randomised-latency arbiter.
// master: requester side (drives req/done).  slave: arbiter side (drives grants).
interface rand_delay_arb_if #(
    parameter int N = 2
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          busy;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  busy
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output busy
    );
endinterface

// File: rtl/rand_delay_arb.sv
// Round-robin arbiter for one shared resource with a pseudo-random wait before
// every grant.  The wait comes from a 5-bit Fibonacci LFSR that steps once per
// arbitration win.  Outputs decode only registered state, so there is no
// combinational path from req/done to gnt/gnt_id/busy.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no owner; pick next requester round-robin from last+1
//  DELAY | winner latched, counting down the random wait; abort if req drops
//  OWN   | gnt[owner] high until done[owner]
module rand_delay_arb #(
    parameter int         N          = 2,
    parameter logic [4:0] DELAY_MASK = 5'h07,
    parameter logic [4:0] SEED       = 5'h01
) (
    input  logic            clk,
    input  logic            rst_n,
    rand_delay_arb_if.slave bus
);
    localparam int         IW       = $clog2(N);
    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [4:0] SEED_EFF = (SEED == 5'h00) ? 5'h01 : SEED;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        OWN   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic [IW-1:0] gnt_id_q;
    logic [IW-1:0] winner;
    logic          winner_found;
    logic [4:0]    cnt;
    logic [4:0]    lfsr;
    logic [4:0]    lfsr_next;

    assign lfsr_next = {lfsr[3:0], lfsr[4] ^ lfsr[2]};

    // Round-robin pick: first active request scanning last+1, last+2, ... mod N.
    always_comb begin
        int idx;
        idx          = 0;
        winner       = '0;
        winner_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!winner_found && bus.req[idx[IW-1:0]]) begin
                winner_found = 1'b1;
                winner       = idx[IW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an owner withdrawing during DELAY aborts the grant.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (winner_found) begin
                    state_next = DELAY;
                end
            end
            DELAY: begin
                if (!bus.req[owner]) begin
                    state_next = IDLE;
                end else if (cnt == 5'd0) begin
                    state_next = OWN;
                end
            end
            OWN: begin
                if (bus.done[owner]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Arbitration datapath: winner/wait latch, LFSR step, countdown, last-owner update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner    <= '0;
            last     <= IW'(N - 1);
            gnt_id_q <= '0;
            cnt      <= 5'd0;
            lfsr     <= SEED_EFF;
        end else begin
            case (state)
                IDLE: begin
                    if (winner_found) begin
                        owner <= winner;
                        cnt   <= lfsr & DELAY_MASK;
                        lfsr  <= lfsr_next;
                    end
                end
                DELAY: begin
                    if (bus.req[owner]) begin
                        if (cnt != 5'd0) begin
                            cnt <= cnt - 5'd1;
                        end else begin
                            gnt_id_q <= owner;
                        end
                    end
                end
                OWN: begin
                    if (bus.done[owner]) begin
                        last <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state; gnt_id keeps the last owner in IDLE.
    always_comb begin
        bus.gnt = '0;
        if (state == OWN) begin
            bus.gnt[owner] = 1'b1;
        end
        bus.busy   = (state != IDLE);
        bus.gnt_id = gnt_id_q;
    end
endmodule

// File: tb/tb_rand_delay_arb.sv
// Directed bench for rand_delay_arb: three instances cover the default
// configuration, a zero-seed/full-mask build, and a four-requester zero-wait build.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_rand_delay_arb;
    logic clk;
    logic rst_a;
    logic rst_b;
    logic rst_c;
    int   errors;
    int   checks;

    rand_delay_arb_if #(.N(2)) ifa ();
    rand_delay_arb_if #(.N(2)) ifb ();
    rand_delay_arb_if #(.N(4)) ifc ();

    rand_delay_arb #(.N(2), .DELAY_MASK(5'h07), .SEED(5'h01)) dut_a (
        .clk  (clk),
        .rst_n(rst_a),
        .bus  (ifa)
    );

    rand_delay_arb #(.N(2), .DELAY_MASK(5'h1F), .SEED(5'h00)) dut_b (
        .clk  (clk),
        .rst_n(rst_b),
        .bus  (ifb)
    );

    rand_delay_arb #(.N(4), .DELAY_MASK(5'h00), .SEED(5'h01)) dut_c (
        .clk  (clk),
        .rst_n(rst_c),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges counted until gnt is seen, bounded; ok=0 means it never came.
    task automatic wait_gnt_a(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            n++;
            ok = (ifa.gnt != '0);
        end
    endtask

    task automatic wait_gnt_b(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            n++;
            ok = (ifb.gnt != '0);
        end
    endtask

    task automatic wait_gnt_c(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            n++;
            ok = (ifc.gnt != '0);
        end
    endtask

    task automatic reset_a();
        rst_a    = 1'b0;
        ifa.req  = '0;
        ifa.done = '0;
        step();
        step();
        rst_a = 1'b1;
    endtask

    task automatic reset_b();
        rst_b    = 1'b0;
        ifb.req  = '0;
        ifb.done = '0;
        step();
        step();
        rst_b = 1'b1;
    endtask

    task automatic reset_c();
        rst_c    = 1'b0;
        ifc.req  = '0;
        ifc.done = '0;
        step();
        step();
        rst_c = 1'b1;
    endtask

    task automatic test_reset();
        rst_a    = 1'b0;
        ifa.req  = 2'b11;
        ifa.done = 2'b11;
        step();
        step();
        checks++;
        if (ifa.gnt !== 2'b00) begin
            errors++;
            $display("FAIL reset_gnt: got %b want 00", ifa.gnt);
        end
        checks++;
        if (ifa.gnt_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt_id: got %0d want 0", ifa.gnt_id);
        end
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", ifa.busy);
        end
        ifa.req  = '0;
        ifa.done = '0;
    endtask

    // SEED=1, MASK=7: first wait is 1, gnt seen after the third edge.
    task automatic test_first_grant();
        int n;
        bit ok;
        reset_a();
        ifa.req = 2'b01;
        step();
        checks++;
        if (ifa.busy !== 1'b1 || ifa.gnt !== 2'b00) begin
            errors++;
            $display("FAIL first_busy: got busy=%b gnt=%b want busy=1 gnt=00", ifa.busy, ifa.gnt);
        end
        wait_gnt_a(n, ok);
        checks++;
        if (!ok || n != 2) begin
            errors++;
            $display("FAIL first_latency: got ok=%0d edges=%0d want ok=1 edges=2", ok, n);
        end
        checks++;
        if (ifa.gnt !== 2'b01 || ifa.gnt_id !== 1'b0) begin
            errors++;
            $display("FAIL first_gnt: got gnt=%b id=%0d want gnt=01 id=0", ifa.gnt, ifa.gnt_id);
        end
        ifa.done = 2'b01;
        step();
        ifa.done = '0;
        ifa.req  = '0;
    endtask

    // Both requesting: owners 0,1,0,1 with waits 1,2,4,1 -> edges-to-gnt = wait+2.
    task automatic test_alternate();
        int n;
        bit ok;
        int exp_n[4]  = '{3, 4, 6, 3};
        int exp_id[4] = '{0, 1, 0, 1};
        logic [1:0] exp_g;
        reset_a();
        ifa.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt_a(n, ok);
            exp_g = (exp_id[k] == 0) ? 2'b01 : 2'b10;
            checks++;
            if (!ok || n != exp_n[k]) begin
                errors++;
                $display("FAIL alt_latency[%0d]: got ok=%0d edges=%0d want edges=%0d", k, ok, n, exp_n[k]);
            end
            checks++;
            if (ifa.gnt !== exp_g || int'(ifa.gnt_id) != exp_id[k]) begin
                errors++;
                $display("FAIL alt_owner[%0d]: got gnt=%b id=%0d want gnt=%b id=%0d", k, ifa.gnt, ifa.gnt_id, exp_g, exp_id[k]);
            end
            step();
            ifa.done = ifa.gnt;
            step();
            ifa.done = '0;
            checks++;
            if (ifa.gnt !== 2'b00 || ifa.busy !== 1'b0) begin
                errors++;
                $display("FAIL alt_release[%0d]: got gnt=%b busy=%b want gnt=00 busy=0", k, ifa.gnt, ifa.busy);
            end
        end
        ifa.req = '0;
    endtask

    // Foreign done and owner withdrawal in OWN are ignored; owner done releases.
    task automatic test_foreign_done();
        int n;
        bit ok;
        reset_a();
        ifa.req = 2'b01;
        wait_gnt_a(n, ok);
        checks++;
        if (!ok || ifa.gnt !== 2'b01) begin
            errors++;
            $display("FAIL foreign_setup: got ok=%0d gnt=%b want gnt=01", ok, ifa.gnt);
        end
        ifa.done = 2'b10;
        step();
        ifa.done = '0;
        checks++;
        if (ifa.gnt !== 2'b01) begin
            errors++;
            $display("FAIL foreign_done: got gnt=%b want 01", ifa.gnt);
        end
        ifa.req = 2'b00;
        step();
        checks++;
        if (ifa.gnt !== 2'b01 || ifa.busy !== 1'b1) begin
            errors++;
            $display("FAIL own_withdraw: got gnt=%b busy=%b want gnt=01 busy=1", ifa.gnt, ifa.busy);
        end
        ifa.done = 2'b01;
        step();
        ifa.done = '0;
        checks++;
        if (ifa.gnt !== 2'b00 || ifa.busy !== 1'b0 || ifa.gnt_id !== 1'b0) begin
            errors++;
            $display("FAIL owner_done: got gnt=%b busy=%b id=%0d want gnt=00 busy=0 id=0", ifa.gnt, ifa.busy, ifa.gnt_id);
        end
    endtask

    // Reset while owner 1 holds: everything clears and the LFSR is reseeded.
    task automatic test_reset_in_own();
        int n;
        bit ok;
        reset_a();
        ifa.req = 2'b11;
        wait_gnt_a(n, ok);
        step();
        ifa.done = ifa.gnt;
        step();
        ifa.done = '0;
        wait_gnt_a(n, ok);
        checks++;
        if (!ok || ifa.gnt !== 2'b10 || ifa.gnt_id !== 1'b1) begin
            errors++;
            $display("FAIL rst_own_setup: got ok=%0d gnt=%b id=%0d want gnt=10 id=1", ok, ifa.gnt, ifa.gnt_id);
        end
        rst_a = 1'b0;
        step();
        checks++;
        if (ifa.gnt !== 2'b00 || ifa.busy !== 1'b0 || ifa.gnt_id !== 1'b0) begin
            errors++;
            $display("FAIL rst_own_clear: got gnt=%b busy=%b id=%0d want gnt=00 busy=0 id=0", ifa.gnt, ifa.busy, ifa.gnt_id);
        end
        rst_a = 1'b1;
        wait_gnt_a(n, ok);
        checks++;
        if (!ok || n != 3 || ifa.gnt !== 2'b01) begin
            errors++;
            $display("FAIL rst_own_reseed: got ok=%0d edges=%0d gnt=%b want edges=3 gnt=01", ok, n, ifa.gnt);
        end
        ifa.req = '0;
        step();
    endtask

    // Zero seed falls back to 1; aborting in DELAY keeps the advanced LFSR (next wait 2).
    task automatic test_abort();
        int n;
        bit ok;
        reset_b();
        ifb.req = 2'b01;
        step();
        checks++;
        if (ifb.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_delay_busy: got %b want 1", ifb.busy);
        end
        ifb.req = 2'b00;
        step();
        checks++;
        if (ifb.busy !== 1'b0 || ifb.gnt !== 2'b00) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b gnt=%b want busy=0 gnt=00", ifb.busy, ifb.gnt);
        end
        step();
        checks++;
        if (ifb.gnt !== 2'b00) begin
            errors++;
            $display("FAIL abort_no_gnt: got %b want 00", ifb.gnt);
        end
        ifb.req = 2'b01;
        wait_gnt_b(n, ok);
        checks++;
        if (!ok || n != 4 || ifb.gnt !== 2'b01) begin
            errors++;
            $display("FAIL abort_next_wait: got ok=%0d edges=%0d gnt=%b want edges=4 gnt=01", ok, n, ifb.gnt);
        end
        ifb.req = '0;
    endtask

    // Four requesters, no wait: order 0,1,2,3,0, a new grant every 4 cycles.
    task automatic test_n4_rotation();
        int n;
        bit ok;
        int exp_id[5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_g;
        reset_c();
        ifc.req = 4'b1111;
        wait_gnt_c(n, ok);
        checks++;
        if (!ok || n != 2) begin
            errors++;
            $display("FAIL n4_first: got ok=%0d edges=%0d want edges=2", ok, n);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                wait_gnt_c(n, ok);
                checks++;
                if (!ok || n + 2 != 4) begin
                    errors++;
                    $display("FAIL n4_period[%0d]: got ok=%0d spacing=%0d want 4", k, ok, n + 2);
                end
            end
            exp_g = 4'b0001 << exp_id[k];
            checks++;
            if (ifc.gnt !== exp_g || int'(ifc.gnt_id) != exp_id[k]) begin
                errors++;
                $display("FAIL n4_owner[%0d]: got gnt=%b id=%0d want gnt=%b id=%0d", k, ifc.gnt, ifc.gnt_id, exp_g, exp_id[k]);
            end
            step();
            ifc.done = ifc.gnt;
            step();
            ifc.done = '0;
        end
        ifc.req = '0;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_a    = 1'b0;
        rst_b    = 1'b0;
        rst_c    = 1'b0;
        ifa.req  = '0;
        ifa.done = '0;
        ifb.req  = '0;
        ifb.done = '0;
        ifc.req  = '0;
        ifc.done = '0;
        test_reset();
        test_first_grant();
        test_alternate();
        test_foreign_done();
        test_reset_in_own();
        test_abort();
        test_n4_rotation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
